// File: rtl/alu_simd_accum_ctrl.sv
// Accumulation sequencer for a 54-bit three-input SIMD adder: feeds the running sum
// back on W, keeps the lane mode fixed per accumulation, and returns the sum over valid/ready.
`timescale 1ns/1ps
module alu_simd_accum_ctrl #(
  parameter int unsigned DATA_W    = 54,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_TERMS = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_X,
  input  logic [DATA_W-1:0] in_Y,
  input  logic              in_cin,
  input  logic              in_last,
  output logic [1:0]        alu_USE_SIMD,
  output logic [DATA_W-1:0] alu_W,
  output logic [DATA_W-1:0] alu_X,
  output logic [DATA_W-1:0] alu_Y,
  output logic              alu_CIN,
  input  logic [DATA_W-1:0] alu_S,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_S,
  output logic [1:0]        out_mode,
  output logic              out_ovf,
  output logic              mode_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  localparam logic [1:0]     MODE_27X27 = 2'b00;
  localparam logic [1:0]     MODE_ILL   = 2'b11;
  localparam logic [CNT_W:0] CNT_LIMIT  = (CNT_W+1)'(MAX_TERMS);
  localparam logic [CNT_W:0] CNT_ONE    = (CNT_W+1)'(1);

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_acc, w_acc_nxt;
  logic [1:0]        r_mode, w_mode_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_ovf, w_ovf_nxt;
  logic              r_mode_err, w_mode_err_nxt;
  logic              w_accept;
  logic [CNT_W:0]    w_cnt_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_mode     <= MODE_27X27;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_mode_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_mode     <= w_mode_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ovf      <= w_ovf_nxt;
      r_mode_err <= w_mode_err_nxt;
    end
  end

  assign in_ready  = (r_state != OUT);
  assign w_accept  = in_valid && in_ready;
  assign w_cnt_inc = {1'b0, r_cnt} + CNT_ONE;

  // Next-state: a beat whose mode cannot join the current accumulation is consumed and flagged.
  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_mode_nxt     = r_mode;
    w_cnt_nxt      = r_cnt;
    w_ovf_nxt      = r_ovf;
    w_mode_err_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (in_mode == MODE_ILL) begin
            w_mode_err_nxt = 1'b1;
          end else begin
            w_acc_nxt  = alu_S;
            w_mode_nxt = in_mode;
            w_cnt_nxt  = CNT_W'(1);
            if (in_last || (CNT_LIMIT == CNT_ONE)) begin
              w_state_nxt = OUT;
              w_ovf_nxt   = !in_last;
            end else begin
              w_state_nxt = ACCUM;
            end
          end
        end
      end
      ACCUM: begin
        if (w_accept) begin
          if (in_mode != r_mode) begin
            w_mode_err_nxt = 1'b1;
          end else begin
            w_acc_nxt = alu_S;
            w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
            if (in_last || (w_cnt_inc == CNT_LIMIT)) begin
              w_state_nxt = OUT;
              w_ovf_nxt   = !in_last;
            end
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
          w_ovf_nxt   = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Adder drive: first beat starts from zero with the incoming mode, later beats feed back acc.
  always_comb begin
    alu_X        = in_X;
    alu_Y        = in_Y;
    alu_W        = '0;
    alu_USE_SIMD = in_mode;
    alu_CIN      = 1'b0;
    if (r_state == IDLE) begin
      alu_CIN = in_cin && (in_mode == MODE_27X27) && !reset;
    end else begin
      alu_W        = r_acc;
      alu_USE_SIMD = r_mode;
    end
  end

  assign out_valid = (r_state == OUT);
  assign out_S     = r_acc;
  assign out_mode  = r_mode;
  assign out_ovf   = r_ovf;
  assign mode_err  = r_mode_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_simd_accum_ctrl.sv
// Bench for alu_simd_accum_ctrl: behavioural SIMD adder, beat-level reference model,
// result scoreboard drained by a monitor, directed cases then randomized accumulations.
`timescale 1ns/1ps
module tb_alu_simd_accum_ctrl;

  localparam int unsigned DATA_W    = 54;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned MAX_TERMS = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready, in_cin, in_last;
  logic [1:0]        in_mode;
  logic [DATA_W-1:0] in_X, in_Y;
  logic [1:0]        alu_USE_SIMD;
  logic [DATA_W-1:0] alu_W, alu_X, alu_Y, alu_S;
  logic              alu_CIN;
  logic              out_valid, out_ready, out_ovf, mode_err, busy;
  logic [DATA_W-1:0] out_S;
  logic [1:0]        out_mode;

  always #5 clk = ~clk;

  alu_simd_accum_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_TERMS(MAX_TERMS)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_X(in_X), .in_Y(in_Y), .in_cin(in_cin), .in_last(in_last),
    .alu_USE_SIMD(alu_USE_SIMD), .alu_W(alu_W), .alu_X(alu_X), .alu_Y(alu_Y),
    .alu_CIN(alu_CIN), .alu_S(alu_S),
    .out_valid(out_valid), .out_ready(out_ready), .out_S(out_S),
    .out_mode(out_mode), .out_ovf(out_ovf), .mode_err(mode_err), .busy(busy)
  );

  // Lane map: 00 one 54-bit lane, 01 three 18-bit lanes, 10 six 9-bit lanes; cin enters lane 0.
  function automatic logic [53:0] simd_add(input logic [53:0] w, input logic [53:0] x,
                                           input logic [53:0] y, input logic cin,
                                           input logic [1:0] m);
    int lw;
    longint unsigned mask, s;
    logic [53:0] r;
    lw   = (m == 2'b01) ? 18 : (m == 2'b10) ? 9 : 54;
    mask = (64'd1 << lw) - 64'd1;
    r    = '0;
    for (int b = 0; b < 54; b += lw) begin
      s = (64'(w >> b) & mask) + (64'(x >> b) & mask) + (64'(y >> b) & mask)
          + ((b == 0) ? 64'(cin) : 64'd0);
      r = r | 54'((s & mask) << b);
    end
    return r;
  endfunction

  assign alu_S = simd_add(alu_W, alu_X, alu_Y, alu_CIN, alu_USE_SIMD);

  typedef struct packed {
    logic [DATA_W-1:0] s;
    logic [1:0]        m;
    logic              o;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, passes = 0, err_seen = 0, ncyc = 0, rdy_ctl = 0;
  bit          m_started;
  logic [1:0]  m_mode;
  logic [53:0] m_sum;
  int          m_cnt, m_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  function automatic void model_reset();
    m_started = 1'b0;
    m_mode    = 2'b00;
    m_sum     = '0;
    m_cnt     = 0;
  endfunction

  // Reference: which beats count, the folded sum, and how the accumulation ends.
  function automatic bit model_beat(input logic [1:0] m, input logic [53:0] x,
                                    input logic [53:0] y, input logic cin, input logic last);
    bit done = 1'b0;
    if (!m_started) begin
      if (m == 2'b11) m_err++;
      else begin
        m_started = 1'b1;
        m_mode    = m;
        m_cnt     = 1;
        m_sum     = simd_add('0, x, y, (m == 2'b00) ? cin : 1'b0, m);
        done      = last || (m_cnt == int'(MAX_TERMS));
      end
    end else if (m != m_mode) begin
      m_err++;
    end else begin
      m_sum = simd_add(m_sum, x, y, 1'b0, m_mode);
      m_cnt++;
      done  = last || (m_cnt == int'(MAX_TERMS));
    end
    if (done) begin
      exp_q.push_back('{m_sum, m_mode, !last});
      m_started = 1'b0;
    end
    return done;
  endfunction

  always @(negedge clk) ncyc++;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_ctl)
        0:       out_ready = (($urandom % 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compare each handshaken result with the scoreboard, and check holding while stalled.
  exp_t              e;
  logic              hold_v = 1'b0;
  logic [DATA_W-1:0] hold_s;
  logic [1:0]        hold_m;
  logic              hold_o;
  always @(negedge clk) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (mode_err) err_seen++;
      if (hold_v && out_valid) begin
        check("hold_out_S", 64'(out_S), 64'(hold_s));
        check("hold_out_mode", 64'(out_mode), 64'(hold_m));
        check("hold_out_ovf", 64'(out_ovf), 64'(hold_o));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_result: got out_S=0x%0h, required no result", out_S);
        end else begin
          e = exp_q.pop_front();
          check("result_S", 64'(out_S), 64'(e.s));
          check("result_mode", 64'(out_mode), 64'(e.m));
          check("result_ovf", 64'(out_ovf), 64'(e.o));
        end
        hold_v = 1'b0;
      end else if (out_valid) begin
        hold_v = 1'b1;
        hold_s = out_S;
        hold_m = out_mode;
        hold_o = out_ovf;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic send_beat(input logic [1:0] m, input logic [53:0] x, input logic [53:0] y,
                           input logic cin, input logic last, output bit done, output int acc_cyc);
    bit rdy;
    int n = 0;
    in_valid = 1'b1; in_mode = m; in_X = x; in_Y = y; in_cin = cin; in_last = last;
    done = 1'b0;
    while (1) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      n++;
      if (rdy) break;
      if (n > 50) begin
        checks++;
        $display("FAIL accept_timeout: in_ready got 0 for %0d cycles, required 1", n);
        in_valid = 1'b0;
        acc_cyc  = ncyc;
        return;
      end
    end
    acc_cyc = ncyc;
    done = model_beat(m, x, y, cin, last);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (done) check("latency_out_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    bit done;
    int c1, c2;
    logic [1:0] m;
    logic [53:0] w_save;
    reset = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_cin = 1'b1; in_last = 1'b0;
    in_X = 54'd9; in_Y = 54'd9;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_S", 64'(out_S), 64'd0);
    check("rst_out_mode", 64'(out_mode), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_mode_err", 64'(mode_err), 64'd0);
    check("rst_alu_W", 64'(alu_W), 64'd0);
    check("rst_alu_CIN", 64'(alu_CIN), 64'd0);
    @(negedge clk);
    reset = 1'b0; in_cin = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of an accumulation discards it.
    rdy_ctl = 1;
    send_beat(2'b00, 54'd10, 54'd20, 1'b0, 1'b0, done, c1);
    send_beat(2'b00, 54'd7, 54'd7, 1'b0, 1'b0, done, c1);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_beat(2'b00, 54'd5, 54'd6, 1'b0, 1'b1, done, c1);
    check("postrst_out_S", 64'(out_S), 64'd11);
    wait_idle();

    // Two-beat 27x27 with carry-in, result held while out_ready stays low.
    rdy_ctl = 2;
    @(posedge clk);
    #1;
    send_beat(2'b00, 54'd1, 54'd2, 1'b1, 1'b0, done, c1);
    send_beat(2'b00, 54'd3, 54'd4, 1'b0, 1'b1, done, c1);
    check("m00_out_S", 64'(out_S), 64'd11);
    check("m00_out_mode", 64'(out_mode), 64'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("stall_out_S", 64'(out_S), 64'd11);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
    end
    rdy_ctl = 1;
    wait_idle();

    // 18-bit lane wraps without leaking into lane 1.
    send_beat(2'b01, 54'h3FFFF, 54'd1, 1'b0, 1'b1, done, c1);
    check("m01_low19", 64'(out_S[18:0]), 64'd0);
    check("m01_out_mode", 64'(out_mode), 64'd1);
    wait_idle();

    // Wrong-mode beat mid-stream is dropped; illegal mode in IDLE is dropped.
    send_beat(2'b10, 54'd3, 54'd4, 1'b0, 1'b0, done, c1);
    send_beat(2'b10, 54'd5, 54'd6, 1'b0, 1'b0, done, c1);
    w_save = alu_W;
    send_beat(2'b00, 54'd100, 54'd100, 1'b0, 1'b1, done, c1);
    check("wrongmode_err", 64'(mode_err), 64'd1);
    check("wrongmode_acc", 64'(alu_W), 64'(w_save));
    check("wrongmode_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    check("err_one_cycle", 64'(mode_err), 64'd0);
    send_beat(2'b10, 54'd1, 54'd1, 1'b0, 1'b1, done, c1);
    check("m10_out_S", 64'(out_S), 64'd20);
    wait_idle();
    send_beat(2'b11, 54'd1, 54'd1, 1'b1, 1'b1, done, c1);
    check("illegal_err", 64'(mode_err), 64'd1);
    check("illegal_busy", 64'(busy), 64'd0);
    check("illegal_out_valid", 64'(out_valid), 64'd0);

    // Term limit forces termination, flag clears on the next accumulation.
    repeat (4) send_beat(2'b00, 54'd1, 54'd0, 1'b0, 1'b0, done, c1);
    check("limit_out_valid", 64'(out_valid), 64'd1);
    check("limit_out_S", 64'(out_S), 64'd4);
    check("limit_out_ovf", 64'(out_ovf), 64'd1);
    wait_idle();
    send_beat(2'b00, 54'd2, 54'd3, 1'b0, 1'b1, done, c1);
    check("after_limit_ovf", 64'(out_ovf), 64'd0);
    check("after_limit_S", 64'(out_S), 64'd5);
    wait_idle();

    // Back-to-back: one bubble between result handshake and next accepted beat.
    send_beat(2'b00, 54'd1, 54'd1, 1'b0, 1'b1, done, c1);
    send_beat(2'b00, 54'd2, 54'd2, 1'b0, 1'b1, done, c2);
    check("bubble_cycles", 64'(c2 - c1), 64'd2);
    wait_idle();

    // Randomized accumulations against the reference model.
    rdy_ctl = 0;
    for (int t = 0; t < 60; t++) begin
      for (int b = 0; b < 20; b++) begin
        int r;
        r = int'($urandom % 10);
        if (r == 0) m = 2'b11;
        else if (m_started && r < 8) m = m_mode;
        else m = 2'($urandom % 3);
        send_beat(m, 54'({$urandom, $urandom}), 54'({$urandom, $urandom}),
                  1'($urandom), ($urandom % 4) == 0, done, c1);
        if (done) break;
        if (($urandom % 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rdy_ctl = 1;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("mode_err_count", 64'(err_seen), 64'(m_err));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
